// File: rtl/wb_arbiter_n_pkg.sv
// Shared definitions for the N-port Wishbone master arbiter.
// Holds the FSM state encoding and a constant ceil-log2 helper.
package wb_arbiter_n_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational priority picker: one-hot winner among request & mask.
// LSB_HIGH_PRIORITY selects whether index 0 or index PORTS-1 wins.
module wb_arb_pick
  import wb_arbiter_n_pkg::*;
#(
  parameter int unsigned PORTS             = 4,
  parameter bit          LSB_HIGH_PRIORITY = 1'b1
) (
  input  logic [PORTS-1:0] request,
  input  logic [PORTS-1:0] mask,
  output logic [PORTS-1:0] grant,
  output logic             valid
);

  logic [PORTS-1:0] req_m;
  logic             found;

  always_comb begin
    req_m = request & mask;
    grant = '0;
    found = 1'b0;
    valid = |req_m;
    for (int unsigned i = 0; i < PORTS; i++) begin
      int unsigned idx;
      idx = LSB_HIGH_PRIORITY ? i : (PORTS - 1 - i);
      if (!found && req_m[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_n.sv
// N-port Wishbone classic master arbiter with registered grant,
// round-robin or fixed priority, and a bus-cycle watchdog that ends hung accesses with ERR.
module wb_arbiter_n
  import wb_arbiter_n_pkg::*;
#(
  parameter int unsigned PORTS                 = 4,
  parameter int unsigned DATA_WIDTH            = 32,
  parameter int unsigned ADDR_WIDTH            = 32,
  parameter int unsigned SELECT_WIDTH          = DATA_WIDTH / 8,
  parameter bit          ARB_TYPE_ROUND_ROBIN  = 1'b1,
  parameter bit          ARB_LSB_HIGH_PRIORITY = 1'b1,
  parameter int unsigned TIMEOUT               = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PORTS*ADDR_WIDTH-1:0]   wbm_adr_i,
  input  logic [PORTS*DATA_WIDTH-1:0]   wbm_dat_i,
  output logic [PORTS*DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic [PORTS-1:0]              wbm_we_i,
  input  logic [PORTS*SELECT_WIDTH-1:0] wbm_sel_i,
  input  logic [PORTS-1:0]              wbm_stb_i,
  input  logic [PORTS-1:0]              wbm_cyc_i,
  output logic [PORTS-1:0]              wbm_ack_o,
  output logic [PORTS-1:0]              wbm_err_o,
  output logic [PORTS-1:0]              wbm_rty_o,
  output logic [ADDR_WIDTH-1:0]         wbs_adr_o,
  output logic [DATA_WIDTH-1:0]         wbs_dat_o,
  output logic                          wbs_we_o,
  output logic [SELECT_WIDTH-1:0]       wbs_sel_o,
  output logic                          wbs_stb_o,
  output logic                          wbs_cyc_o,
  input  logic [DATA_WIDTH-1:0]         wbs_dat_i,
  input  logic                          wbs_ack_i,
  input  logic                          wbs_err_i,
  input  logic                          wbs_rty_i,
  output logic [PORTS-1:0]              grant_o,
  output logic                          grant_valid_o,
  output logic                          timeout_o
);

  arb_state_t              state;
  logic                    busy;
  logic [PORTS-1:0]        last_grant;
  logic [PORTS-1:0]        rr_mask;
  logic                    rr_seen;
  logic [PORTS-1:0]        pick_m_grant, pick_u_grant, next_grant;
  logic                    pick_m_valid, pick_u_valid;
  logic [ADDR_WIDTH-1:0]   mux_adr;
  logic [DATA_WIDTH-1:0]   mux_dat;
  logic                    mux_we, mux_stb, mux_cyc;
  logic [SELECT_WIDTH-1:0] mux_sel;
  logic                    slave_term;
  logic                    wd_fire;

  assign busy       = (state == ST_BUSY);
  assign slave_term = wbs_ack_i | wbs_err_i | wbs_rty_i;

  // Mask keeps only ports strictly after the last winner in priority order.
  always_comb begin
    rr_mask = '0;
    rr_seen = 1'b0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      int unsigned idx;
      idx          = ARB_LSB_HIGH_PRIORITY ? k : (PORTS - 1 - k);
      rr_mask[idx] = rr_seen;
      rr_seen      = rr_seen | last_grant[idx];
    end
  end

  wb_arb_pick #(
    .PORTS             (PORTS),
    .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
  ) u_pick_masked (
    .request (wbm_cyc_i),
    .mask    (rr_mask),
    .grant   (pick_m_grant),
    .valid   (pick_m_valid)
  );

  wb_arb_pick #(
    .PORTS             (PORTS),
    .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
  ) u_pick_unmasked (
    .request (wbm_cyc_i),
    .mask    ('1),
    .grant   (pick_u_grant),
    .valid   (pick_u_valid)
  );

  always_comb begin
    next_grant = pick_u_grant;
    if (ARB_TYPE_ROUND_ROBIN && pick_m_valid) next_grant = pick_m_grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      grant_o       <= '0;
      grant_valid_o <= 1'b0;
      last_grant    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_u_valid) begin
            state         <= ST_BUSY;
            grant_o       <= next_grant;
            grant_valid_o <= 1'b1;
            last_grant    <= next_grant;
          end
        end
        ST_BUSY: begin
          if (!mux_cyc) begin
            state         <= ST_IDLE;
            grant_o       <= '0;
            grant_valid_o <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // grant_o is cleared outside BUSY, so the mux drives all zeros when idle.
  always_comb begin
    mux_adr = '0;
    mux_dat = '0;
    mux_we  = 1'b0;
    mux_sel = '0;
    mux_stb = 1'b0;
    mux_cyc = 1'b0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      if (grant_o[k]) begin
        mux_adr = wbm_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        mux_dat = wbm_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
        mux_we  = wbm_we_i[k];
        mux_sel = wbm_sel_i[k*SELECT_WIDTH +: SELECT_WIDTH];
        mux_stb = wbm_stb_i[k];
        mux_cyc = wbm_cyc_i[k];
      end
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam int unsigned     CNT_W = clog2(TIMEOUT + 1);
      localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);
      logic [CNT_W-1:0] wd_count;
      logic             wd_pending;

      assign wd_pending = busy && mux_stb && !slave_term;
      assign wd_fire    = wd_pending && (wd_count == LIMIT);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wd_count <= '0;
        end else if (wd_pending && !wd_fire) begin
          wd_count <= wd_count + 1'b1;
        end else begin
          wd_count <= '0;
        end
      end
    end else begin : g_no_wdog
      assign wd_fire = 1'b0;
    end
  endgenerate

  assign wbs_adr_o = mux_adr;
  assign wbs_dat_o = mux_dat;
  assign wbs_we_o  = mux_we;
  assign wbs_sel_o = mux_sel;
  assign wbs_stb_o = mux_stb & ~wd_fire;
  assign wbs_cyc_o = mux_cyc;
  assign timeout_o = wd_fire;

  assign wbm_dat_o = {PORTS{wbs_dat_i}};
  assign wbm_ack_o = grant_o & {PORTS{busy & wbs_ack_i}};
  assign wbm_err_o = grant_o & {PORTS{busy & (wbs_err_i | wd_fire)}};
  assign wbm_rty_o = grant_o & {PORTS{busy & wbs_rty_i}};

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Directed bench for wb_arbiter_n: one round-robin and one fixed-priority instance
// driven from shared master/slave stimulus, expected grant order held in a queue.
module tb_wb_arbiter_n;

  localparam int unsigned P  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [P*AW-1:0] m_adr;
  logic [P*DW-1:0] m_dat;
  logic [P-1:0]    m_we, m_stb, m_cyc;
  logic [P*SW-1:0] m_sel;
  logic [DW-1:0]   s_dat;
  logic            s_ack, s_err, s_rty;

  logic [P*DW-1:0] dat_o_a, dat_o_b;
  logic [P-1:0]    ack_a, err_a, rty_a, grant_a;
  logic [P-1:0]    ack_b, err_b, rty_b, grant_b;
  logic [AW-1:0]   sadr_a, sadr_b;
  logic [DW-1:0]   sdat_a, sdat_b;
  logic [SW-1:0]   ssel_a, ssel_b;
  logic            swe_a, sstb_a, scyc_a, gv_a, to_a;
  logic            swe_b, sstb_b, scyc_b, gv_b, to_b;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned exp_q[$];

  always #5 clk = ~clk;

  wb_arbiter_n #(
    .PORTS(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
    .ARB_TYPE_ROUND_ROBIN(1'b1), .ARB_LSB_HIGH_PRIORITY(1'b1), .TIMEOUT(16)
  ) u_rr (
    .clk(clk), .rst_n(rst_n),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_dat_o(dat_o_a), .wbm_we_i(m_we),
    .wbm_sel_i(m_sel), .wbm_stb_i(m_stb), .wbm_cyc_i(m_cyc),
    .wbm_ack_o(ack_a), .wbm_err_o(err_a), .wbm_rty_o(rty_a),
    .wbs_adr_o(sadr_a), .wbs_dat_o(sdat_a), .wbs_we_o(swe_a), .wbs_sel_o(ssel_a),
    .wbs_stb_o(sstb_a), .wbs_cyc_o(scyc_a),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .grant_o(grant_a), .grant_valid_o(gv_a), .timeout_o(to_a)
  );

  wb_arbiter_n #(
    .PORTS(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
    .ARB_TYPE_ROUND_ROBIN(1'b0), .ARB_LSB_HIGH_PRIORITY(1'b1), .TIMEOUT(16)
  ) u_fp (
    .clk(clk), .rst_n(rst_n),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_dat_o(dat_o_b), .wbm_we_i(m_we),
    .wbm_sel_i(m_sel), .wbm_stb_i(m_stb), .wbm_cyc_i(m_cyc),
    .wbm_ack_o(ack_b), .wbm_err_o(err_b), .wbm_rty_o(rty_b),
    .wbs_adr_o(sadr_b), .wbs_dat_o(sdat_b), .wbs_we_o(swe_b), .wbs_sel_o(ssel_b),
    .wbs_stb_o(sstb_b), .wbs_cyc_o(scyc_b),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .grant_o(grant_b), .grant_valid_o(gv_b), .timeout_o(to_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    m_adr = '0; m_dat = '0; m_we = '0; m_sel = '0; m_stb = '0; m_cyc = '0;
    s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Each granted master holds two BUSY cycles, drops CYC, and re-requests in the
  // idle gap only for the first reraise_rounds rounds.
  task automatic run_arb(input bit use_fp, input int unsigned rounds,
                         input int unsigned reraise_rounds);
    logic [P-1:0] g;
    int unsigned  exp_port, p, waited;
    for (int unsigned r = 0; r < rounds; r++) begin
      @(negedge clk);
      g = use_fp ? grant_b : grant_a;
      waited = 0;
      while (g == '0 && waited < 10) begin
        @(negedge clk);
        g = use_fp ? grant_b : grant_a;
        waited++;
      end
      if (exp_q.size() == 0) begin
        check("sb_underflow", 64'(exp_q.size()), 64'd1);
        exp_port = 0;
      end else begin
        exp_port = exp_q.pop_front();
      end
      check(use_fp ? "fp_grant" : "rr_grant", 64'(g), 64'(1) << exp_port);
      p = exp_port;
      for (int unsigned i = 0; i < P; i++) if (g[i]) p = i;
      @(posedge clk); #1;
      @(posedge clk); #1;
      m_cyc[p] = 1'b0;
      m_stb[p] = 1'b0;
      @(negedge clk);
      check("release_cyc_low", 64'(use_fp ? scyc_b : scyc_a), 64'd0);
      @(posedge clk); #1;
      if (r < reraise_rounds) begin
        m_cyc[p] = 1'b1;
        m_stb[p] = 1'b1;
      end
      @(negedge clk);
      check("idle_gap", 64'(use_fp ? gv_b : gv_a), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    do_reset();
    @(negedge clk);
    check("reset_grant", 64'(grant_a), 64'd0);
    check("reset_gvalid", 64'(gv_a), 64'd0);
    check("reset_timeout", 64'(to_a), 64'd0);
    check("reset_wbs_cyc", 64'(scyc_a), 64'd0);

    // single master read on port 2, slave acks on the third cycle after grant request
    @(posedge clk); #1;
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_we[2] = 1'b0;
    m_adr[2*AW +: AW] = 32'h1000_0020;
    m_sel[2*SW +: SW] = 4'hF;
    @(negedge clk);
    check("latency_cyc_n", 64'(scyc_a), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("latency_cyc_n1", 64'(scyc_a), 64'd1);
    check("p2_grant", 64'(grant_a), 64'h4);
    check("p2_adr", 64'(sadr_a), 64'h1000_0020);
    check("p2_sel", 64'(ssel_a), 64'hF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    s_ack = 1'b1; s_dat = 32'hCAFE_BABE;
    @(negedge clk);
    check("p2_ack", 64'(ack_a), 64'h4);
    check("p2_err", 64'(err_a), 64'h0);
    check("p2_rdata", 64'(dat_o_a[2*DW +: DW]), 64'hCAFE_BABE);
    @(posedge clk); #1;
    s_ack = 1'b0; m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
    @(negedge clk);
    check("p2_drop_cyc", 64'(scyc_a), 64'd0);
    check("p2_drop_still_busy", 64'(gv_a), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("p2_back_idle", 64'(gv_a), 64'd0);

    // round robin with all four ports requesting
    do_reset();
    @(posedge clk); #1;
    m_cyc = '1; m_stb = '1;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    run_arb(1'b0, 5, 5);

    // fixed priority: port 0 keeps winning until 0..2 stop requesting
    do_reset();
    @(posedge clk); #1;
    m_cyc = '1; m_stb = '1;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    run_arb(1'b1, 6, 2);

    // watchdog: slave never responds on port 1
    do_reset();
    @(posedge clk); #1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    for (int unsigned k = 1; k <= 17; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k < 16) begin
        check("wd_quiet", 64'({to_a, err_a}), 64'h0);
        check("wd_stb_on", 64'(sstb_a), 64'd1);
      end else if (k == 16) begin
        check("wd_timeout", 64'(to_a), 64'd1);
        check("wd_err", 64'(err_a), 64'h2);
        check("wd_stb_off", 64'(sstb_a), 64'd0);
        check("wd_cyc_held", 64'(scyc_a), 64'd1);
      end else begin
        check("wd_one_pulse", 64'(to_a), 64'd0);
      end
    end

    // slave ack lands on the watchdog limit cycle for port 3
    do_reset();
    @(posedge clk); #1;
    m_cyc[3] = 1'b1; m_stb[3] = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    s_ack = 1'b1;
    #1;
    check("lim_ack", 64'(ack_a), 64'h8);
    check("lim_no_err", 64'(err_a), 64'h0);
    check("lim_no_timeout", 64'(to_a), 64'd0);
    @(posedge clk); #1;
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;

    // async reset in the middle of a port 2 cycle
    do_reset();
    @(posedge clk); #1;
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    @(posedge clk); #1;
    check("mid_grant_before", 64'(grant_a), 64'h4);
    #2;
    rst_n = 1'b0;
    s_ack = 1'b1;
    #1;
    check("mid_grant_zero", 64'(grant_a), 64'h0);
    check("mid_cyc_zero", 64'(scyc_a), 64'd0);
    check("mid_gvalid_zero", 64'(gv_a), 64'd0);
    check("mid_no_ack", 64'(ack_a), 64'h0);
    s_ack = 1'b0;
    m_cyc = '1; m_stb = '1;
    exp_q.push_back(0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if (exp_q.size() != 0) check("post_reset_grant", 64'(grant_a), 64'(1) << exp_q.pop_front());
    m_cyc = '0; m_stb = '0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_n.md
# wb_arbiter_n

N-port Wishbone master arbiter that multiplexes PORTS classic-cycle masters onto one slave port. It sits between CPU/DMA masters and a shared interconnect segment, and generalises the 2-port arbiter to any port count. Grant is registered, with a selectable round-robin or fixed-priority policy. A bus-cycle watchdog terminates hung slave accesses with ERR.

## Interface
- PORTS, 4: number of master ports (2..32)
- DATA_WIDTH, 32: data bus width (8/16/32/64)
- ADDR_WIDTH, 32: address width
- SELECT_WIDTH, DATA_WIDTH/8: byte-select width
- ARB_TYPE_ROUND_ROBIN, 1: 1 = round robin, 0 = fixed priority
- ARB_LSB_HIGH_PRIORITY, 1: 1 = lowest index wins ties/fixed priority
- TIMEOUT, 256: max cycles STB may wait for termination; 0 disables watchdog
- Clocking/reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wbm_adr_i  in  PORTS*ADDR_WIDTH  per-master address, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- wbm_dat_i  in  PORTS*DATA_WIDTH  per-master write data
- wbm_dat_o  out  PORTS*DATA_WIDTH  read data, every slice = wbs_dat_i
- wbm_we_i  in  PORTS  write enable
- wbm_sel_i  in  PORTS*SELECT_WIDTH  byte selects
- wbm_stb_i / wbm_cyc_i  in  PORTS  strobe / cycle
- wbm_ack_o / wbm_err_o / wbm_rty_o  out  PORTS  terminations, only on granted port
- wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o, wbs_stb_o, wbs_cyc_o  out  slave-side mirrors of granted master
- wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i  in  slave responses
- grant_o  out  PORTS  registered one-hot grant
- grant_valid_o  out  1  grant active (state BUSY)
- timeout_o  out  1  one-cycle pulse when watchdog fires

## Operation
- FSM: IDLE, BUSY. Reset: IDLE, grant_o=0, grant_valid_o=0, timeout_o=0, watchdog count=0, RR pointer = port 0 highest priority.
- IDLE: if any wbm_cyc_i high, register winner into grant_o and go BUSY; else stay IDLE.
- Winner selection: fixed priority uses request vector directly; round robin first picks from requests masked to indices strictly above (LSB_HIGH=1) or below (LSB_HIGH=0) the last winner, falling back to unmasked if the masked set is empty. RR pointer updates on each grant.
- BUSY: slave outputs are a combinational mux of the granted master; wbs_cyc_o=1; terminations routed only to the granted port, others 0. Non-granted outputs to slave all zero when not BUSY.
- BUSY -> IDLE when granted wbm_cyc_i is low; that cycle wbs_cyc_o/wbs_stb_o are already low (mux follows master). Exactly one IDLE cycle between consecutive grants, ensuring CYC deasserts between masters.
- Watchdog (TIMEOUT>0): counter increments each BUSY cycle with wbs_stb_o=1 and no ack/err/rty; clears on any termination or when stb low. When count reaches TIMEOUT-1 and still unterminated: that cycle forces granted wbm_err_o=1, suppresses wbs_stb_o, pulses timeout_o, clears counter. Slave response in the same cycle as the timeout has priority (no timeout fires).
- Counter width clog2(TIMEOUT+1); saturate never needed since it clears on fire.
- Reset mid-transfer: all outputs to reset values immediately (async), grant dropped, no termination delivered.

## Timing
- Grant latency: cyc asserted at cycle n -> wbs_cyc_o at n+1.
- Release: cyc dropped at m -> state IDLE at m+1; next grant visible at m+2.
- Slave->master response path is combinational (0 cycles).
- Timeout fires exactly TIMEOUT cycles after first unterminated STB cycle.

## Structure
- Shared package/include: FSM state encodings, clog2 helper function.
- One sub-module: wb_arb_pick (combinational masked priority picker, params PORTS, LSB_HIGH_PRIORITY; inputs request, mask; outputs one-hot grant, valid). Instanced twice (masked, unmasked) for round robin.

## Test plan
- Single master port 2 cycles read, slave ack after 3 cycles -> wbs_cyc_o rises 1 cycle after cyc, wbm_ack_o[2]=1 only, wbm_dat_o = slave data.
- All 4 ports request continuously, RR, LSB_HIGH=1, each holds 2 cycles -> grant order 0,1,2,3,0 with one idle cycle between.
- Same with ARB_TYPE_ROUND_ROBIN=0 -> port 0 always regranted after release; port 3 never until 0-2 drop.
- Slave never responds, TIMEOUT=16 -> wbm_err_o pulse on granted port exactly 16 cycles after STB, timeout_o=1 one cycle, stb low that cycle.
- Slave acks in same cycle as watchdog limit -> ack delivered, no err, no timeout_o.
- rst_n asserted mid-burst -> grant_o=0, wbs_cyc_o=0 immediately; after release port 0 wins first.
